// File: rtl/combi_encoder.sv
// ============================================================================
// Module   : combi_encoder
// Brief    : Encodes abstract op requests into 32-bit ARM or RISC-V words;
//            LI expands into 2 (RISC-V) or 5 (ARM) words.
//            Optional macro COMBI_ENC_COND_EN adds the in_cond port (ARM cond).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module combi_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_arm,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
`ifdef COMBI_ENC_COND_EN
  input  logic [3:0]       in_cond,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             illegal,
  output logic [CNT_W-1:0] words_emitted
);

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_AND  = 4'd2;
  localparam logic [3:0] c_OP_ORR  = 4'd3;
  localparam logic [3:0] c_OP_ADDI = 4'd4;
  localparam logic [3:0] c_OP_LW   = 4'd5;
  localparam logic [3:0] c_OP_SW   = 4'd6;
  localparam logic [3:0] c_OP_LI   = 4'd7;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              arm_q, arm_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]        w_cond_in;
  logic [3:0]        w_exp_cond;
  logic              w_xfer;
  logic              w_accept;
  logic [31:0]       w_single_word;
  logic [3:0]        w_cmd;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;

`ifdef COMBI_ENC_COND_EN
  logic [3:0] cond_q, cond_d;
  assign w_cond_in  = in_cond;
  assign w_exp_cond = cond_q;
`else
  assign w_cond_in  = 4'hE;
  assign w_exp_cond = 4'hE;
`endif

  // Word idx of the LI expansion; RISC-V uses idx 0..1, ARM idx 0..4.
  function automatic logic [31:0] li_word(input logic arm, input logic [3:0] cond,
                                          input logic [4:0] rd, input logic [31:0] imm,
                                          input logic [2:0] idx);
    logic [19:0] hi;
    logic [31:0] word;
    hi = imm[31:12] + {19'd0, imm[11]};
    if (!arm) begin
      word = (idx == 3'd0) ? {hi, rd, 7'b0110111}
                           : {imm[11:0], rd, 3'b000, rd, 7'b0010011};
    end else begin
      case (idx)
        3'd0:    word = {cond, 3'b001, 4'b0000, 1'b0, rd[3:0], rd[3:0], 4'h0, 8'h00};
        3'd1:    word = {cond, 3'b001, 4'b1100, 1'b0, rd[3:0], rd[3:0], 4'h0, imm[7:0]};
        3'd2:    word = {cond, 3'b001, 4'b1100, 1'b0, rd[3:0], rd[3:0], 4'hC, imm[15:8]};
        3'd3:    word = {cond, 3'b001, 4'b1100, 1'b0, rd[3:0], rd[3:0], 4'h8, imm[23:16]};
        default: word = {cond, 3'b001, 4'b1100, 1'b0, rd[3:0], rd[3:0], 4'h4, imm[31:24]};
      endcase
    end
    return word;
  endfunction

  assign w_xfer   = out_valid_q & out_ready;
  assign in_ready = (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_cmd = 4'b0100;
    w_f3  = 3'b000;
    w_f7  = 7'b0000000;
    case (in_op)
      c_OP_SUB: begin w_cmd = 4'b0010; w_f7 = 7'b0100000; end
      c_OP_AND: begin w_cmd = 4'b0000; w_f3 = 3'b111; end
      c_OP_ORR: begin w_cmd = 4'b1100; w_f3 = 3'b110; end
      default:  ;
    endcase
  end

  always_comb begin
    w_single_word = 32'h0;
    case (in_op)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_ORR:
        w_single_word = in_arm
          ? {w_cond_in, 3'b000, w_cmd, 1'b0, in_rs1[3:0], in_rd[3:0], 8'h00, in_rs2[3:0]}
          : {w_f7, in_rs2, in_rs1, w_f3, in_rd, 7'b0110011};
      c_OP_ADDI:
        w_single_word = in_arm
          ? {w_cond_in, 3'b001, 4'b0100, 1'b0, in_rs1[3:0], in_rd[3:0], 4'h0, in_imm[7:0]}
          : {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      c_OP_LW:
        w_single_word = in_arm
          ? {w_cond_in, 8'b0101_1001, in_rs1[3:0], in_rd[3:0], in_imm[11:0]}
          : {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      c_OP_SW:
        w_single_word = in_arm
          ? {w_cond_in, 8'b0101_1000, in_rs1[3:0], in_rs2[3:0], in_imm[11:0]}
          : {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    arm_d       = arm_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
`ifdef COMBI_ENC_COND_EN
    cond_d      = cond_q;
`endif
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~w_xfer;
    out_last_d  = out_last_q;
    illegal_d   = 1'b0;
    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, w_xfer};
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          arm_d = in_arm;
          rd_d  = in_rd;
          imm_d = in_imm;
`ifdef COMBI_ENC_COND_EN
          cond_d = in_cond;
`endif
          if (in_op == c_OP_LI) begin
            out_data_d  = li_word(in_arm, w_cond_in, in_rd, in_imm, 3'd0);
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            idx_d       = 3'd1;
            state_d     = S_EXPAND;
          end else if (in_op > c_OP_LI) begin
            illegal_d = 1'b1;
          end else begin
            out_data_d  = w_single_word;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
          end
        end
      end
      S_EXPAND: begin
        if (w_xfer) begin
          out_data_d  = li_word(arm_q, w_exp_cond, rd_q, imm_q, idx_q);
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == (arm_q ? 3'd4 : 3'd1));
          idx_d       = idx_q + 3'd1;
          if (out_last_d) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      arm_q       <= 1'b0;
      rd_q        <= 5'd0;
      imm_q       <= 32'h0;
`ifdef COMBI_ENC_COND_EN
      cond_q      <= 4'hE;
`endif
      out_data_q  <= 32'h0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arm_q       <= arm_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
`ifdef COMBI_ENC_COND_EN
      cond_q      <= cond_d;
`endif
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign illegal       = illegal_q;
  assign words_emitted = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_combi_encoder.sv
// ============================================================================
// Module   : tb_combi_encoder
// Brief    : Table-driven, scoreboarded bench for combi_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_combi_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_arm;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_last, illegal;
  logic [31:0] out_data;
  logic [15:0] words_emitted;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        rand_bp = 1'b0;
  logic [32:0] sbq[$];

  typedef struct packed {
    logic            arm;
    logic [3:0]      op;
    logic [4:0]      rd, rs1, rs2;
    logic [31:0]     imm;
    logic [2:0]      n;
    logic [4:0][31:0] w;
  } vec_t;

  vec_t vecs[$];

  combi_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_arm(in_arm), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
`ifdef COMBI_ENC_COND_EN
    .in_cond(4'hE),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .illegal(illegal), .words_emitted(words_emitted)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic arm, input logic [3:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [2:0] n, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4);
    vec_t v;
    v.arm = arm; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: a word is popped on the negedge before its transfer edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h last=%b, expected no word", out_data, out_last);
      end else begin
        logic [32:0] e;
        e = sbq.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL word: got data=%h last=%b, expected data=%h last=%b",
                   out_data, out_last, e[31:0], e[32]);
        end
      end
      exp_cnt = exp_cnt + 16'd1;
    end
    if (!reset && out_valid && !out_last) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_mid_li: got %b, expected 0", in_ready);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input vec_t v);
    int t;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_arm = v.arm; in_op = v.op;
    in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1");
      #1 in_valid = 1'b0;
    end else begin
      @(posedge clk);
      for (int i = 0; i < int'(v.n); i++) sbq.push_back({(i == int'(v.n) - 1), v.w[i]});
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
    check("words_emitted", {16'h0, words_emitted}, {16'h0, exp_cnt});
  endtask

  initial begin
    vec_t v;
    int   t;
    reset = 1'b1; in_valid = 1'b0; in_arm = 1'b0; in_op = 4'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0; out_ready = 1'b1;

    vecs.push_back(mk(0, 0, 5, 6, 7, 32'h0, 1, 32'h007302B3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 3, 32'h0, 1, 32'hE0421003, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 1, 2, 0, 32'h8, 1, 32'hE5921008, 0, 0, 0, 0));
    vecs.push_back(mk(0, 7, 10, 0, 0, 32'h12345FFF, 2, 32'h12346537, 32'hFFF50513, 0, 0, 0));
    vecs.push_back(mk(1, 7, 4, 0, 0, 32'hAABBCCDD, 5, 32'hE2044000, 32'hE38440DD,
                      32'hE3844CCC, 32'hE38448BB, 32'hE38444AA));
    vecs.push_back(mk(0, 1, 1, 2, 3, 32'h0, 1, 32'h403100B3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 3, 4, 5, 32'h0, 1, 32'h005271B3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6, 0, 2, 8, 32'h7FC, 1, 32'h7E812E23, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4, 3, 5, 0, 32'h1FF, 1, 32'hE28530FF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6, 0, 1, 7, 32'h10, 1, 32'hE5817010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4, 1, 0, 0, 32'hFFFFFFFF, 1, 32'hFFF00093, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 31, 14, 29, 32'h0, 1, 32'hE18EF00D, 0, 0, 0, 0));
    vecs.push_back(mk(0, 7, 1, 0, 0, 32'h00000800, 2, 32'h000010B7, 32'h80008093, 0, 0, 0));
    vecs.push_back(mk(0, 7, 2, 0, 0, 32'hFFFFF800, 2, 32'h00000137, 32'h80010113, 0, 0, 0));
    vecs.push_back(mk(1, 15, 1, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", {31'h0, out_last}, 32'h0);
    check("rst_illegal", {31'h0, illegal}, 32'h0);
    check("rst_words_emitted", {16'h0, words_emitted}, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", {31'h0, in_ready}, 32'h1);

    for (int pass = 0; pass < 2; pass++) begin
      rand_bp = (pass == 1);
      foreach (vecs[i]) begin
        send(vecs[i]);
        drain();
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Backpressure on the first LI word.
    out_ready = 1'b0;
    send(vecs[3]);
    for (int c = 0; c < 3; c++) begin
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_out_data", out_data, 32'h12346537);
      check("bp_out_last", {31'h0, out_last}, 32'h0);
      check("bp_words_emitted", {16'h0, words_emitted}, {16'h0, exp_cnt});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Illegal op 9.
    send(mk(0, 9, 1, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0));
    check("illegal_pulse", {31'h0, illegal}, 32'h1);
    check("illegal_no_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("illegal_drop", {31'h0, illegal}, 32'h0);
    check("illegal_no_valid2", {31'h0, out_valid}, 32'h0);

    // Reset after the second ARM LI word has transferred.
    send(vecs[4]);
    t = 0;
    while (sbq.size() > 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("mid_li_pending", sbq.size(), 32'd3);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mr_out_valid", {31'h0, out_valid}, 32'h0);
    check("mr_words_emitted", {16'h0, words_emitted}, 32'h0);
    check("mr_out_last", {31'h0, out_last}, 32'h0);
    sbq.delete();
    exp_cnt = 16'd0;
    @(negedge clk) reset = 1'b0;
    #2;
    check("mr_in_ready", {31'h0, in_ready}, 32'h1);
    send(vecs[0]);
    drain();
    send(vecs[4]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
